writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (32), register/data width; SHALL be 32 or 64.
REQ-002 Parameter REG_ADDR_W, default 5, register-file address width.
REQ-003 Localparam OFS_W = log2(DATA_WIDTH/8), byte-offset width (2 at 32, 3 at 64).
REQ-004 Clock and reset SHALL be exactly: one clock; reset is asynchronous and active-low.
REQ-005 clk_i  in  1  clock, all state on rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 valid_i  in  1  memory-stage instruction valid.
REQ-008 ready_o  out  1  unit can accept; transfer = valid_i && ready_o.
REQ-009 result_src_i  in  2  00 ALU, 01 load, 10 PC+4, 11 aux.
REQ-010 funct3_i  in  3  load size/sign (RISC-V encoding).
REQ-011 byte_offset_i  in  OFS_W  load address low bits.
REQ-012 alu_result_i, pc_plus_4_i, aux_data_i  in  DATA_WIDTH each  result candidates.
REQ-013 reg_write_i  in  1; rd_addr_i  in  REG_ADDR_W  destination.
REQ-014 mem_rvalid_i  in  1; mem_rdata_i  in  DATA_WIDTH  load response.
REQ-015 rf_we_o  out  1; rf_addr_o  out  REG_ADDR_W; rf_wdata_o  out  DATA_WIDTH  registered write port.
REQ-016 misaligned_o  out  1  one-cycle fault pulse; spurious_o  out  1  sticky error.

Function
REQ-017 FSM states IDLE, WAIT_LOAD; ready_o SHALL be 1 in IDLE, 0 in WAIT_LOAD.
REQ-018 Non-load transfer (result_src_i != 01): rf_* outputs SHALL present the selected result on the following cycle (latency 1), state stays IDLE.
REQ-019 Load transfer with mem_rvalid_i high same cycle: SHALL complete as REQ-018 with extracted data; state stays IDLE.
REQ-020 Load transfer with mem_rvalid_i low: SHALL capture funct3, offset, rd, reg_write into holding regs and enter WAIT_LOAD.
REQ-021 WAIT_LOAD with mem_rvalid_i high: SHALL write extracted data next cycle and return to IDLE; mem_rvalid_i low: remain, no write.
REQ-022 rf_we_o SHALL be a single-cycle pulse = captured reg_write && rd != 0 && !misaligned; rf_addr_o/rf_wdata_o SHALL hold last values when rf_we_o is 0.
REQ-023 Extraction: lane = mem_rdata_i >> (8*offset); 000 LB sign-ext byte, 001 LH sign-ext half, 010 LW (sign-ext at 64), 100 LBU, 101 LHU zero-ext; 64 only: 011 LD, 110 LWU.
REQ-024 Unsupported funct3 (incl. 011/110 at 32, 111 always) SHALL be treated as full-width word load, no fault.
REQ-025 Misaligned: LH/LHU offset bit0=1, LW/LWU offset[1:0]!=0, LD offset!=0 -> misaligned_o pulse at write cycle, rf_we_o 0.
REQ-026 mem_rvalid_i high in IDLE without a load transfer that cycle SHALL set spurious_o until reset; data ignored.
REQ-027 Non-load result mux SHALL not depend on funct3_i or byte_offset_i.

Reset
REQ-028 rst_ni low SHALL asynchronously force IDLE, rf_we_o 0, rf_addr_o 0, rf_wdata_o 0, misaligned_o 0, spurious_o 0, ready_o 1.
REQ-029 Reset during WAIT_LOAD SHALL drop the pending load with no write; a late mem_rvalid_i after release SHALL set spurious_o.

Verification
REQ-030 ALU: src 00, alu 0x0000_1234, rd 5, reg_write 1 -> next cycle rf_we_o 1, addr 5, data 0x0000_1234; following cycle rf_we_o 0.
REQ-031 rd 0 with reg_write 1, src 10, pc+4 0x100 -> rf_we_o stays 0 throughout.
REQ-032 LB offset 3, rdata 0x80FF_0000, rvalid 2 cycles late -> ready_o 0 for 2 cycles, then write 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-033 LH offset 1 -> misaligned_o pulse, rf_we_o 0; LHU offset 2, rdata 0xABCD_0000 -> 0x0000_ABCD.
REQ-034 Reset asserted mid-WAIT_LOAD -> all outputs 0, ready_o 1; rvalid pulse after release -> spurious_o 1 and held.
REQ-035 DATA_WIDTH 64: LWU offset 4, rdata 0xDEAD_BEEF_0000_0000 -> 0x0000_0000_DEAD_BEEF; LW same -> 0xFFFF_FFFF_DEAD_BEEF.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: selects the result (ALU / load / PC+4 / aux), extracts load data,
// and drives a registered single-cycle register-file write port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

// state     | meaning
// IDLE      | accepting transfers; non-load or load-with-data writes next cycle
// WAIT_LOAD | load accepted without data; holding funct3/offset/rd until mem_rvalid_i
module writeback_unit #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int REG_ADDR_W = 5,
  localparam int OFS_W = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [1:0]            result_src_i,
  input  logic [2:0]            funct3_i,
  input  logic [OFS_W-1:0]      byte_offset_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] pc_plus_4_i,
  input  logic [DATA_WIDTH-1:0] aux_data_i,
  input  logic                  reg_write_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  misaligned_o,
  output logic                  spurious_o
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_LOAD = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [2:0]            f3_q, f3_d;
  logic [OFS_W-1:0]      ofs_q, ofs_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  mis_q, mis_d;
  logic                  spur_q, spur_d;

  logic                  xfer, is_load;
  logic [2:0]            ld_f3;
  logic [OFS_W-1:0]      ld_ofs;
  logic [DATA_WIDTH-1:0] lane, ld_data, res_mux;
  logic                  ld_mis;

  assign ready_o = (state_q == IDLE);
  assign xfer    = valid_i && ready_o;
  assign is_load = (result_src_i == 2'b01);

  // Extraction uses the live inputs in IDLE and the held fields while waiting.
  assign ld_f3  = (state_q == WAIT_LOAD) ? f3_q  : funct3_i;
  assign ld_ofs = (state_q == WAIT_LOAD) ? ofs_q : byte_offset_i;
  assign lane   = mem_rdata_i >> {ld_ofs, 3'b000};

  always_comb begin
    ld_data = mem_rdata_i;
    ld_mis  = 1'b0;
    case (ld_f3)
      3'b000: ld_data = DATA_WIDTH'($signed(lane[7:0]));
      3'b001: begin
        ld_data = DATA_WIDTH'($signed(lane[15:0]));
        ld_mis  = ld_ofs[0];
      end
      3'b010: begin
        ld_data = DATA_WIDTH'($signed(lane[31:0]));
        ld_mis  = |ld_ofs[1:0];
      end
      3'b100: ld_data = DATA_WIDTH'(lane[7:0]);
      3'b101: begin
        ld_data = DATA_WIDTH'(lane[15:0]);
        ld_mis  = ld_ofs[0];
      end
      3'b011: if (DATA_WIDTH == 64) ld_mis = |ld_ofs;
      3'b110: if (DATA_WIDTH == 64) begin
        ld_data = DATA_WIDTH'(lane[31:0]);
        ld_mis  = |ld_ofs[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    case (result_src_i)
      2'b10:   res_mux = pc_plus_4_i;
      2'b11:   res_mux = aux_data_i;
      default: res_mux = alu_result_i;
    endcase
  end

  logic                  do_wb, wb_rw, wb_mis;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    ofs_d   = ofs_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    spur_d  = spur_q;
    do_wb   = 1'b0;
    wb_rw   = reg_write_i;
    wb_rd   = rd_addr_i;
    wb_data = res_mux;
    wb_mis  = 1'b0;
    if (state_q == IDLE) begin
      if (xfer && !is_load) begin
        do_wb = 1'b1;
      end else if (xfer && mem_rvalid_i) begin
        do_wb   = 1'b1;
        wb_data = ld_data;
        wb_mis  = ld_mis;
      end else if (xfer) begin
        f3_d    = funct3_i;
        ofs_d   = byte_offset_i;
        rd_d    = rd_addr_i;
        rw_d    = reg_write_i;
        state_d = WAIT_LOAD;
      end
      if (mem_rvalid_i && !(xfer && is_load)) spur_d = 1'b1;
    end else if (mem_rvalid_i) begin
      do_wb   = 1'b1;
      wb_rw   = rw_q;
      wb_rd   = rd_q;
      wb_data = ld_data;
      wb_mis  = ld_mis;
      state_d = IDLE;
    end

    rf_we_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    mis_d      = 1'b0;
    if (do_wb) begin
      if (wb_mis) begin
        mis_d = 1'b1;
      end else if (wb_rw && (wb_rd != '0)) begin
        rf_we_d    = 1'b1;
        rf_addr_d  = wb_rd;
        rf_wdata_d = wb_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      f3_q       <= '0;
      ofs_q      <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      mis_q      <= 1'b0;
      spur_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      ofs_q      <= ofs_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      mis_q      <= mis_d;
      spur_q     <= spur_d;
    end
  end

  assign rf_we_o      = rf_we_q;
  assign rf_addr_o    = rf_addr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign misaligned_o = mis_q;
  assign spurious_o   = spur_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit at DATA_WIDTH 32 and 64.
module tb_writeback_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        valid, rw, rvalid, ready, we, mis, spur;
  logic [1:0]  src, ofs;
  logic [2:0]  f3;
  logic [4:0]  rd, waddr;
  logic [31:0] alu, pc4, aux, rdata, wdata;

  logic        w_valid, w_rw, w_rvalid, w_ready, w_we, w_mis, w_spur;
  logic [1:0]  w_src;
  logic [2:0]  w_f3, w_ofs;
  logic [4:0]  w_rd, w_waddr;
  logic [63:0] w_alu, w_pc4, w_aux, w_rdata, w_wdata;

  writeback_unit #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready),
    .result_src_i(src), .funct3_i(f3), .byte_offset_i(ofs),
    .alu_result_i(alu), .pc_plus_4_i(pc4), .aux_data_i(aux),
    .reg_write_i(rw), .rd_addr_i(rd), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .rf_we_o(we), .rf_addr_o(waddr), .rf_wdata_o(wdata),
    .misaligned_o(mis), .spurious_o(spur)
  );

  writeback_unit #(.DATA_WIDTH(64), .REG_ADDR_W(5)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(w_valid), .ready_o(w_ready),
    .result_src_i(w_src), .funct3_i(w_f3), .byte_offset_i(w_ofs),
    .alu_result_i(w_alu), .pc_plus_4_i(w_pc4), .aux_data_i(w_aux),
    .reg_write_i(w_rw), .rd_addr_i(w_rd), .mem_rvalid_i(w_rvalid), .mem_rdata_i(w_rdata),
    .rf_we_o(w_we), .rf_addr_o(w_waddr), .rf_wdata_o(w_wdata),
    .misaligned_o(w_mis), .spurious_o(w_spur)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { logic [4:0] addr; logic [63:0] data; logic mis; } exp_t;
  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  logic [4:0]  last_addr;
  logic [31:0] last_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (we || mis)) begin
      if (q32.size() == 0) begin
        chk("wb32_unexpected", {62'd0, we, mis}, 64'd0);
      end else begin
        e32 = q32.pop_front();
        chk("wb32_mis", 64'(mis), 64'(e32.mis));
        chk("wb32_we", 64'(we), 64'(!e32.mis));
        if (!e32.mis) begin
          chk("wb32_addr", 64'(waddr), 64'(e32.addr));
          chk("wb32_data", 64'(wdata), e32.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (w_we || w_mis)) begin
      if (q64.size() == 0) begin
        chk("wb64_unexpected", {62'd0, w_we, w_mis}, 64'd0);
      end else begin
        e64 = q64.pop_front();
        chk("wb64_mis", 64'(w_mis), 64'(e64.mis));
        chk("wb64_we", 64'(w_we), 64'(!e64.mis));
        if (!e64.mis) begin
          chk("wb64_addr", 64'(w_waddr), 64'(e64.addr));
          chk("wb64_data", w_wdata, e64.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle32();
    valid = 0; rvalid = 0; src = 0; f3 = 0; ofs = 0; rw = 0; rd = 0;
    rdata = 0; alu = 0; pc4 = 0; aux = 0;
  endtask

  task automatic idle64();
    w_valid = 0; w_rvalid = 0; w_src = 0; w_f3 = 0; w_ofs = 0; w_rw = 0; w_rd = 0;
    w_rdata = 0; w_alu = 0; w_pc4 = 0; w_aux = 0;
  endtask

  task automatic op32(input logic [1:0] t_src, input logic [31:0] t_alu, input logic [31:0] t_pc4,
                      input logic [31:0] t_aux, input logic t_rw, input logic [4:0] t_rd,
                      input logic t_we, input logic [31:0] t_exp);
    valid = 1; src = t_src; f3 = 3'($urandom); ofs = 2'($urandom);
    alu = t_alu; pc4 = t_pc4; aux = t_aux; rw = t_rw; rd = t_rd;
    rdata = $urandom;
    if (t_we) q32.push_back('{t_rd, 64'(t_exp), 1'b0});
    tick();
    idle32();
    if (t_we) begin last_addr = t_rd; last_data = t_exp; end
  endtask

  task automatic load32(input logic [2:0] t_f3, input logic [1:0] t_ofs, input logic [31:0] t_rdata,
                        input logic [4:0] t_rd, input logic [31:0] t_exp, input logic t_mis);
    valid = 1; src = 2'b01; f3 = t_f3; ofs = t_ofs; rd = t_rd; rw = 1;
    rvalid = 1; rdata = t_rdata; alu = $urandom; pc4 = $urandom; aux = $urandom;
    q32.push_back('{t_rd, 64'(t_exp), t_mis});
    tick();
    idle32();
    if (t_mis) begin
      chk("mis_hold_addr", 64'(waddr), 64'(last_addr));
      chk("mis_hold_data", 64'(wdata), 64'(last_data));
    end else begin
      last_addr = t_rd; last_data = t_exp;
    end
  endtask

  task automatic late_load32(input logic [2:0] t_f3, input logic [1:0] t_ofs, input logic [31:0] t_rdata,
                             input logic [4:0] t_rd, input int waits, input logic [31:0] t_exp,
                             input logic t_mis);
    valid = 1; src = 2'b01; f3 = t_f3; ofs = t_ofs; rd = t_rd; rw = 1; rvalid = 0;
    tick();
    idle32();
    for (int i = 0; i < waits; i++) begin
      chk("late_ready_low", 64'(ready), 64'd0);
      f3 = 3'($urandom); ofs = 2'($urandom); rd = 5'($urandom);
      if (i == waits - 1) begin
        rvalid = 1; rdata = t_rdata;
        q32.push_back('{t_rd, 64'(t_exp), t_mis});
      end
      tick();
    end
    idle32();
    chk("late_ready_back", 64'(ready), 64'd1);
    if (!t_mis) begin last_addr = t_rd; last_data = t_exp; end
  endtask

  task automatic load64(input logic [2:0] t_f3, input logic [2:0] t_ofs, input logic [63:0] t_rdata,
                        input logic [4:0] t_rd, input logic [63:0] t_exp, input logic t_mis);
    w_valid = 1; w_src = 2'b01; w_f3 = t_f3; w_ofs = t_ofs; w_rd = t_rd; w_rw = 1;
    w_rvalid = 1; w_rdata = t_rdata; w_alu = {$urandom, $urandom};
    q64.push_back('{t_rd, t_exp, t_mis});
    tick();
    idle64();
  endtask

  typedef struct { logic [2:0] f3; logic [1:0] ofs; logic [31:0] rdat; logic [31:0] exp; logic mis; } ld32_t;
  ld32_t tbl32 [14] = '{
    '{3'b000, 2'd0, 32'h1234_5678, 32'h0000_0078, 1'b0},
    '{3'b000, 2'd2, 32'h1234_5678, 32'h0000_0034, 1'b0},
    '{3'b000, 2'd1, 32'h0000_F100, 32'hFFFF_FFF1, 1'b0},
    '{3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001, 1'b0},
    '{3'b001, 2'd1, 32'h1234_5678, 32'h0000_0000, 1'b1},
    '{3'b010, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0},
    '{3'b010, 2'd2, 32'hCAFE_F00D, 32'h0000_0000, 1'b1},
    '{3'b100, 2'd1, 32'h0000_9A00, 32'h0000_009A, 1'b0},
    '{3'b101, 2'd2, 32'hABCD_0000, 32'h0000_ABCD, 1'b0},
    '{3'b101, 2'd3, 32'hABCD_0000, 32'h0000_0000, 1'b1},
    '{3'b111, 2'd0, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0},
    '{3'b011, 2'd0, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0},
    '{3'b110, 2'd0, 32'h8000_0001, 32'h8000_0001, 1'b0},
    '{3'b001, 2'd0, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0}
  };

  typedef struct { logic [2:0] f3; logic [2:0] ofs; logic [63:0] rdat; logic [63:0] exp; logic mis; } ld64_t;
  ld64_t tbl64 [8] = '{
    '{3'b110, 3'd4, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF, 1'b0},
    '{3'b010, 3'd4, 64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0},
    '{3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0},
    '{3'b011, 3'd4, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b1},
    '{3'b010, 3'd2, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b1},
    '{3'b000, 3'd7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0},
    '{3'b101, 3'd6, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF, 1'b0},
    '{3'b111, 3'd0, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle32();
    idle64();
    last_addr = 0;
    last_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_addr", 64'(waddr), 64'd0);
    chk("rst_data", 64'(wdata), 64'd0);
    chk("rst_mis", 64'(mis), 64'd0);
    chk("rst_spur", 64'(spur), 64'd0);
    chk("rst64_ready", 64'(w_ready), 64'd1);
    rst_n = 1;
    tick();

    op32(2'b00, 32'h0000_1234, 32'h0, 32'h0, 1'b1, 5'd5, 1'b1, 32'h0000_1234);
    chk("alu_we_high", 64'(we), 64'd1);
    tick();
    chk("alu_we_pulse", 64'(we), 64'd0);

    op32(2'b10, 32'h0, 32'h0000_0100, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0);
    tick();
    chk("rd0_hold_addr", 64'(waddr), 64'd5);
    chk("rd0_hold_data", 64'(wdata), 64'h1234);

    op32(2'b10, 32'h1111_1111, 32'h0000_0200, 32'h2222_2222, 1'b1, 5'd9, 1'b1, 32'h0000_0200);
    op32(2'b11, 32'h1111_1111, 32'h3333_3333, 32'hA5A5_5A5A, 1'b1, 5'd31, 1'b1, 32'hA5A5_5A5A);
    op32(2'b00, 32'h7777_0001, 32'h3333_3333, 32'h4444_4444, 1'b0, 5'd3, 1'b0, 32'h0);
    op32(2'b00, 32'h0BAD_F00D, 32'h3333_3333, 32'h4444_4444, 1'b1, 5'd17, 1'b1, 32'h0BAD_F00D);

    for (int i = 0; i < 14; i++)
      load32(tbl32[i].f3, tbl32[i].ofs, tbl32[i].rdat, 5'(i + 1), tbl32[i].exp, tbl32[i].mis);

    late_load32(3'b000, 2'd3, 32'h80FF_0000, 5'd12, 2, 32'hFFFF_FF80, 1'b0);
    late_load32(3'b100, 2'd3, 32'h80FF_0000, 5'd13, 2, 32'h0000_0080, 1'b0);
    late_load32(3'b001, 2'd1, 32'h80FF_0000, 5'd14, 1, 32'h0, 1'b1);
    late_load32(3'b101, 2'd2, 32'hABCD_0000, 5'd15, 3, 32'h0000_ABCD, 1'b0);
    tick();
    chk("no_spur_32", 64'(spur), 64'd0);

    w_valid = 1; w_src = 2'b00; w_rw = 1; w_rd = 5'd6; w_alu = 64'h1122_3344_5566_7788;
    w_f3 = 3'b011; w_ofs = 3'd5;
    q64.push_back('{5'd6, 64'h1122_3344_5566_7788, 1'b0});
    tick();
    idle64();
    for (int i = 0; i < 8; i++)
      load64(tbl64[i].f3, tbl64[i].ofs, tbl64[i].rdat, 5'(i + 20), tbl64[i].exp, tbl64[i].mis);
    tick();
    chk("no_spur_64", 64'(w_spur), 64'd0);
    w_valid = 1; w_src = 2'b10; w_rw = 1; w_rd = 5'd2; w_pc4 = 64'h0000_0001_0000_0004;
    w_rvalid = 1; w_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    q64.push_back('{5'd2, 64'h0000_0001_0000_0004, 1'b0});
    tick();
    idle64();
    chk("spur_64_nonload", 64'(w_spur), 64'd1);

    valid = 1; src = 2'b01; f3 = 3'b010; ofs = 2'd0; rd = 5'd4; rw = 1; rvalid = 0;
    tick();
    idle32();
    chk("wait_before_rst", 64'(ready), 64'd0);
    #2 rst_n = 0;
    #1;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_we", 64'(we), 64'd0);
    chk("midrst_addr", 64'(waddr), 64'd0);
    chk("midrst_data", 64'(wdata), 64'd0);
    chk("midrst_mis", 64'(mis), 64'd0);
    chk("midrst_spur", 64'(spur), 64'd0);
    @(negedge clk);
    rst_n = 1;
    tick();
    rvalid = 1; rdata = 32'hFFFF_FFFF;
    tick();
    idle32();
    chk("late_rvalid_spur", 64'(spur), 64'd1);
    chk("late_rvalid_no_we", 64'(we), 64'd0);
    repeat (3) tick();
    chk("spur_sticky", 64'(spur), 64'd1);

    tick();
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q64_drained", 64'(q64.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
